// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler: scans four hex slots onto one seg7 decoder with blanking gaps
// and frame-aligned commit of shadow digit registers to the displayed set.
module seg7_scan_scheduler #(
    parameter logic [23:0] DWELL_CYCLES = 24'd10,
    parameter logic [23:0] BLANK_CYCLES = 24'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       wr_blank,
    input  logic       commit,
    output logic       commit_pending,
    output logic [3:0] digit_code,
    output logic       digit_blank,
    output logic [3:0] digit_sel,
    output logic       frame_start
);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t      state, state_nx;
    logic [1:0]  idx, idx_nx;
    logic [23:0] cnt, cnt_nx;
    logic        frame_nx, apply, pending_nx;
    logic [3:0]  shadow [4];
    logic [3:0]  active [4];
    logic [3:0]  shadow_blank, active_blank;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + 24'd1;
        frame_nx = 1'b0;
        if (!ena) begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
            cnt_nx   = 24'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    idx_nx   = 2'd0;
                    cnt_nx   = 24'd0;
                    frame_nx = 1'b1;
                end
                BLANK: if (cnt == BLANK_CYCLES - 24'd1) begin
                    state_nx = SHOW;
                    cnt_nx   = 24'd0;
                end
                SHOW: if (cnt == DWELL_CYCLES - 24'd1) begin
                    state_nx = BLANK;
                    cnt_nx   = 24'd0;
                    idx_nx   = idx + 2'd1;
                    frame_nx = (idx == 2'd3);
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = 2'd0;
                    cnt_nx   = 24'd0;
                end
            endcase
        end
    end

    // A pending commit lands only where no frame is mid-display: on a frame start or while idle.
    assign apply      = commit_pending && (state == IDLE || frame_nx);
    assign pending_nx = apply ? 1'b0 : (commit_pending || commit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= 2'd0;
            cnt            <= 24'd0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
            shadow_blank   <= 4'b1111;
            active_blank   <= 4'b1111;
            commit_pending <= 1'b0;
            wr_ready       <= 1'b1;
            digit_sel      <= 4'd0;
            digit_code     <= 4'd0;
            digit_blank    <= 1'b1;
            frame_start    <= 1'b0;
        end else begin
            state          <= state_nx;
            idx            <= idx_nx;
            cnt            <= cnt_nx;
            if (wr_valid && wr_ready) begin
                shadow[wr_addr]       <= wr_data;
                shadow_blank[wr_addr] <= wr_blank;
            end
            if (apply) begin
                for (int i = 0; i < 4; i++) active[i] <= shadow[i];
                active_blank <= shadow_blank;
            end
            commit_pending <= pending_nx;
            wr_ready       <= !pending_nx;
            digit_sel      <= (state_nx == SHOW) ? 4'b0001 << idx_nx : 4'd0;
            digit_code     <= (state_nx == SHOW) ? active[idx_nx] : 4'd0;
            digit_blank    <= (state_nx == SHOW) ? active_blank[idx_nx] : 1'b1;
            frame_start    <= frame_nx;
        end
    end
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb_seg7_scan_scheduler: scoreboard bench; expected slot tuples are queued when stimulus
// is driven and matched against tuples observed while the display scans.
module tb_seg7_scan_scheduler;
    logic       clk = 1'b0;
    logic       rst_n, ena, wr_valid, wr_blank, commit;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready, commit_pending, digit_blank, frame_start;
    logic [3:0] digit_code, digit_sel;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic [24:0] exp_q [$];
    logic [24:0] obs_q [$];

    seg7_scan_scheduler dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_blank(wr_blank), .commit(commit),
        .commit_pending(commit_pending), .digit_code(digit_code), .digit_blank(digit_blank),
        .digit_sel(digit_sel), .frame_start(frame_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tuple: {sel, code, blank, gap cycles, dwell cycles}
    task automatic push_frame(input logic [15:0] codes, input logic [3:0] blanks);
        logic [3:0] sel;
        for (int i = 0; i < 4; i++) begin
            sel = 4'b0001 << i;
            exp_q.push_back({sel, codes[4*i +: 4], blanks[i], 8'd2, 8'd10});
        end
    endtask

    task automatic scan_frame(output int fs_at);
        int n, g, d;
        logic [3:0] sel, code;
        logic blk;
        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        fs_at = (frame_start === 1'b1) ? cyc : -1;
        for (int s = 0; s < 4; s++) begin
            g = 0;
            while (digit_sel === 4'b0 && g < 200) begin
                g++;
                step();
            end
            sel = digit_sel;
            code = digit_code;
            blk = digit_blank;
            d = 0;
            while (digit_sel === sel && sel !== 4'b0 && d < 200) begin
                if (digit_code !== code || digit_blank !== blk) blk = 1'bx;
                d++;
                step();
            end
            obs_q.push_back({sel, code, blk, g[7:0], d[7:0]});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b0; wr_valid = 1'b0; commit = 1'b0;
        wr_addr = 2'd0; wr_data = 4'd0; wr_blank = 1'b0;
        step(2);
        tests_run++;
        if ({digit_sel, digit_code, digit_blank, frame_start, commit_pending, wr_ready} !== 12'b0000_0000_1001) begin
            tests_failed++;
            $display("FAIL reset_outputs: got sel=%b code=%h blank=%b fs=%b pend=%b rdy=%b, expected 0000/0/1/0/0/1",
                     digit_sel, digit_code, digit_blank, frame_start, commit_pending, wr_ready);
        end
    endtask

    task automatic test_scan;
        int f0, f1;
        logic [24:0] e, o;
        rst_n = 1'b1; ena = 1'b1;
        step();
        tests_run++;
        if (frame_start !== 1'b1 || digit_sel !== 4'b0) begin
            tests_failed++;
            $display("FAIL first_frame_start: got fs=%b sel=%b, expected fs=1 sel=0000", frame_start, digit_sel);
        end
        push_frame(16'h0000, 4'hF);
        push_frame(16'h0000, 4'hF);
        scan_frame(f0);
        scan_frame(f1);
        tests_run++;
        if (f0 < 0 || f1 - f0 != 48) begin
            tests_failed++;
            $display("FAIL frame_period: got %0d (f0=%0d), expected 48", f1 - f0, f0);
        end
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL scan_dark entry%0d: got %h, expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_commit;
        int n, f;
        bit lit, stall_bad;
        logic [24:0] e, o;
        step(5);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = i[1:0]; wr_data = 4'(i + 1); wr_blank = 1'b0;
            step();
        end
        wr_valid = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        tests_run++;
        if (commit_pending !== 1'b1 || wr_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL commit_pending_set: got pend=%b rdy=%b, expected 1/0", commit_pending, wr_ready);
        end
        wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'h7; wr_blank = 1'b0;
        n = 0; lit = 0; stall_bad = 0;
        while (frame_start !== 1'b1 && n < 100) begin
            if (digit_blank === 1'b0) lit = 1;
            if (commit_pending !== 1'b1 || wr_ready !== 1'b0) stall_bad = 1;
            step();
            n++;
        end
        tests_run++;
        if (lit || stall_bad || n >= 100) begin
            tests_failed++;
            $display("FAIL commit_window: got lit=%0d stall_bad=%0d waited=%0d, expected 0/0/<100", lit, stall_bad, n);
        end
        tests_run++;
        if (commit_pending !== 1'b0 || wr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL commit_applied: got pend=%b rdy=%b, expected 0/1", commit_pending, wr_ready);
        end
        push_frame(16'h4321, 4'h0);
        scan_frame(f);
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL commit_frame slot%0d: got %h, expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_same_cycle;
        int f;
        logic [24:0] e, o;
        step(3);
        wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 4'hA; wr_blank = 1'b0; commit = 1'b1;
        step();
        wr_valid = 1'b0; commit = 1'b0;
        tests_run++;
        if (commit_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_cycle_pending: got %b, expected 1", commit_pending);
        end
        push_frame(16'h4A71, 4'h0);
        scan_frame(f);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL same_cycle_frame slot%0d: got %h, expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_ena_drop;
        int n, f;
        logic [24:0] e, o;
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 4'hE; wr_blank = 1'b0; commit = 1'b1;
        step();
        wr_valid = 1'b0; commit = 1'b0;
        n = 0;
        while (digit_sel !== 4'b0010 && n < 100) begin
            step();
            n++;
        end
        step(3);
        ena = 1'b0;
        step();
        tests_run++;
        if (digit_sel !== 4'b0 || commit_pending !== 1'b1 || frame_start !== 1'b0 || n >= 100) begin
            tests_failed++;
            $display("FAIL ena_drop: got sel=%b pend=%b fs=%b waited=%0d, expected 0000/1/0/<100",
                     digit_sel, commit_pending, frame_start, n);
        end
        ena = 1'b1;
        step();
        tests_run++;
        if (frame_start !== 1'b1 || commit_pending !== 1'b0 || digit_sel !== 4'b0) begin
            tests_failed++;
            $display("FAIL ena_restart: got fs=%b pend=%b sel=%b, expected 1/0/0000", frame_start, commit_pending, digit_sel);
        end
        push_frame(16'hEA71, 4'h0);
        scan_frame(f);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL restart_frame slot%0d: got %h, expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        int f;
        logic [24:0] e, o;
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'hF; wr_blank = 1'b0; commit = 1'b1;
        step();
        wr_valid = 1'b0; commit = 1'b0;
        step(14);
        tests_run++;
        if (commit_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_pending: got %b, expected 1", commit_pending);
        end
        rst_n = 1'b0;
        step();
        tests_run++;
        if ({digit_sel, digit_code, digit_blank, frame_start, commit_pending, wr_ready} !== 12'b0000_0000_1001) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got sel=%b code=%h blank=%b fs=%b pend=%b rdy=%b, expected 0000/0/1/0/0/1",
                     digit_sel, digit_code, digit_blank, frame_start, commit_pending, wr_ready);
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if (frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_start: got fs=%b, expected 1", frame_start);
        end
        push_frame(16'h0000, 4'hF);
        scan_frame(f);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL post_reset_frame slot%0d: got %h, expected %h", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_commit();
        test_same_cycle();
        test_ena_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
